// File: rtl/sram_arb_pkg.sv
`default_nettype none
// ============================================================================
// sram_arb_pkg : shared FSM state type and default geometry for sram_arbiter
// Revision 1.0
// ============================================================================
package sram_arb_pkg;

   localparam int c_SRAM_AW      = 19;
   localparam int c_SRAM_DW      = 8;
   localparam int c_SRAM_FIFO_LG = 2;
   localparam int c_SRAM_WS      = 2;
   localparam int c_SRAM_RL      = 2;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_WSETUP = 3'd1,
      S_WPULSE = 3'd2,
      S_WHOLD  = 3'd3,
      S_READ   = 3'd4,
      S_ACK    = 3'd5
   } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/sram_arb_fifo.sv
`default_nettype none
// ============================================================================
// sram_arb_fifo : small synchronous FIFO, same-cycle push/pop even when full
// Revision 1.0
// ============================================================================
module sram_arb_fifo #(
   parameter int W  = 27,
   parameter int LG = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_push,
   input  logic         i_pop,
   input  logic [W-1:0] i_din,
   output logic [W-1:0] o_dout,
   output logic         o_full,
   output logic         o_empty
);

   localparam int c_DEPTH = 1 << LG;

   logic [W-1:0]  r_mem [c_DEPTH];
   logic [LG-1:0] r_wr;
   logic [LG-1:0] r_rd;
   logic [LG:0]   r_cnt;
   logic          w_do_push;
   logic          w_do_pop;

   assign o_empty   = (r_cnt == '0);
   assign o_full    = (r_cnt == (LG+1)'(c_DEPTH));
   assign o_dout    = r_mem[r_rd];
   assign w_do_pop  = i_pop && !o_empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign w_do_push = i_push && (!o_full || w_do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_do_push) r_wr <= r_wr + 1'b1;
         if (w_do_pop)  r_rd <= r_rd + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr] <= i_din;
   end

endmodule
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// sram_arbiter : shares one async SRAM between the ROM download stream
//                (buffered, top priority) and the CPU req/ack port
// Revision 1.0
// ============================================================================
module sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter int AW      = c_SRAM_AW,
   parameter int DW      = c_SRAM_DW,
   parameter int FIFO_LG = c_SRAM_FIFO_LG,
   parameter int WS      = c_SRAM_WS,
   parameter int RL      = c_SRAM_RL
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          init,
   input  logic          iniW,
   input  logic [AW-1:0] iniA,
   input  logic [DW-1:0] iniD,
   input  logic          cpuReq,
   input  logic          cpuWe,
   input  logic [AW-1:0] cpuA,
   input  logic [DW-1:0] cpuD,
   output logic [DW-1:0] cpuQ,
   output logic          cpuAck,
   output logic          busy,
   output logic          ovf,
   output logic [AW-1:0] sramA,
   output logic [DW-1:0] sramD,
   output logic          sramDe,
   input  logic [DW-1:0] sramQ,
   output logic          sramWe,
   output logic          sramOe
);

   localparam int         c_CW    = $clog2(((WS > RL) ? WS : RL) + 1);
   localparam logic [c_CW-1:0] c_WS_M1 = c_CW'(WS - 1);
   localparam logic [c_CW-1:0] c_RL_M1 = c_CW'(RL - 1);

   arb_state_t     r_state;
   arb_state_t     w_state_nxt;
   logic [c_CW-1:0] r_cnt;
   logic [c_CW-1:0] w_cnt_nxt;
   logic           w_pop;
   logic           w_take_cpu;
   logic           w_fifo_full;
   logic           w_fifo_empty;
   logic [AW+DW-1:0] w_fifo_dout;
   logic           w_in_write;

   logic           r_pend_v;
   logic           r_pend_we;
   logic [AW-1:0]  r_pend_a;
   logic [DW-1:0]  r_pend_d;
   logic           r_svc;
   logic           r_op_dl;
   logic           r_op_we;
   logic [AW-1:0]  r_op_a;
   logic [DW-1:0]  r_op_d;

   sram_arb_fifo #(
      .W  (AW + DW),
      .LG (FIFO_LG)
   ) u_fifo (
      .clk     (clock),
      .rst_n   (reset),
      .i_push  (iniW),
      .i_pop   (w_pop),
      .i_din   ({iniA, iniD}),
      .o_dout  (w_fifo_dout),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

   assign w_in_write = (r_state == S_WSETUP) || (r_state == S_WPULSE) || (r_state == S_WHOLD);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_pop       = 1'b0;
      w_take_cpu  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_fifo_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = S_WSETUP;
            end else if (r_pend_v) begin
               w_take_cpu = 1'b1;
               if (r_pend_we) begin
                  w_state_nxt = S_WSETUP;
               end else begin
                  w_state_nxt = S_READ;
                  w_cnt_nxt   = c_RL_M1;
               end
            end
         end
         S_WSETUP: begin
            w_state_nxt = S_WPULSE;
            w_cnt_nxt   = c_WS_M1;
         end
         S_WPULSE: begin
            if (r_cnt == '0) w_state_nxt = S_WHOLD;
            else             w_cnt_nxt   = r_cnt - 1'b1;
         end
         S_WHOLD:  w_state_nxt = r_op_dl ? S_IDLE : S_ACK;
         S_READ: begin
            if (r_cnt == '0) w_state_nxt = S_ACK;
            else             w_cnt_nxt   = r_cnt - 1'b1;
         end
         S_ACK:    w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Single pending slot; new requests are ignored until the current one is acked.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_pend_v  <= 1'b0;
         r_pend_we <= 1'b0;
         r_pend_a  <= '0;
         r_pend_d  <= '0;
         r_svc     <= 1'b0;
         r_op_dl   <= 1'b0;
         r_op_we   <= 1'b0;
         r_op_a    <= '0;
         r_op_d    <= '0;
      end else begin
         if (w_take_cpu) begin
            r_pend_v <= 1'b0;
         end else if (cpuReq && !r_pend_v && !r_svc) begin
            r_pend_v  <= 1'b1;
            r_pend_we <= cpuWe;
            r_pend_a  <= cpuA;
            r_pend_d  <= cpuD;
         end
         if (w_take_cpu)             r_svc <= 1'b1;
         else if (r_state == S_ACK)  r_svc <= 1'b0;
         if (w_pop) begin
            r_op_dl <= 1'b1;
            r_op_we <= 1'b1;
            r_op_a  <= w_fifo_dout[AW+DW-1:DW];
            r_op_d  <= w_fifo_dout[DW-1:0];
         end else if (w_take_cpu) begin
            r_op_dl <= 1'b0;
            r_op_we <= r_pend_we;
            r_op_a  <= r_pend_a;
            r_op_d  <= r_pend_d;
         end
      end
   end

   // Pins follow the state one cycle later, so every SRAM control is a flop output.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cpuQ   <= '0;
         cpuAck <= 1'b0;
         busy   <= 1'b1;
         ovf    <= 1'b0;
         sramA  <= '0;
         sramD  <= '0;
         sramDe <= 1'b0;
         sramWe <= 1'b1;
         sramOe <= 1'b1;
      end else begin
         sramDe <= w_in_write;
         sramWe <= (r_state != S_WPULSE);
         sramOe <= (r_state != S_READ);
         cpuAck <= (r_state == S_ACK);
         if ((r_state == S_ACK) && !r_op_we) cpuQ <= sramQ;
         if (r_state != S_IDLE) begin
            sramA <= r_op_a;
            sramD <= r_op_d;
         end
         if (iniW && w_fifo_full && !w_pop) ovf <= 1'b1;
         busy <= !init || !w_fifo_empty || (r_op_dl && w_in_write);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// tb_sram_arbiter : table-driven and scoreboard bench with a behavioural SRAM
// Revision 1.0
// ============================================================================
module tb_sram_arbiter;

   localparam int AW = 19;
   localparam int DW = 8;
   localparam int WS = 2;
   localparam int RL = 2;

   logic          clock  = 1'b0;
   logic          reset  = 1'b1;
   logic          init   = 1'b0;
   logic          iniW   = 1'b0;
   logic [AW-1:0] iniA   = '0;
   logic [DW-1:0] iniD   = '0;
   logic          cpuReq = 1'b0;
   logic          cpuWe  = 1'b0;
   logic [AW-1:0] cpuA   = '0;
   logic [DW-1:0] cpuD   = '0;
   logic [DW-1:0] cpuQ;
   logic          cpuAck;
   logic          busy;
   logic          ovf;
   logic [AW-1:0] sramA;
   logic [DW-1:0] sramD;
   logic          sramDe;
   logic [DW-1:0] sramQ;
   logic          sramWe;
   logic          sramOe;

   bit [DW-1:0] mem [0:(1<<AW)-1];

   sram_arbiter #(.AW(AW), .DW(DW), .FIFO_LG(2), .WS(WS), .RL(RL)) dut (
      .clock (clock),  .reset (reset),  .init   (init),   .iniW  (iniW),
      .iniA  (iniA),   .iniD  (iniD),   .cpuReq (cpuReq), .cpuWe (cpuWe),
      .cpuA  (cpuA),   .cpuD  (cpuD),   .cpuQ   (cpuQ),   .cpuAck(cpuAck),
      .busy  (busy),   .ovf   (ovf),    .sramA  (sramA),  .sramD (sramD),
      .sramDe(sramDe), .sramQ (sramQ),  .sramWe (sramWe), .sramOe(sramOe)
   );

   always #5 clock = ~clock;

   always @(posedge clock) if (!sramWe && sramDe) mem[sramA] <= sramD;
   assign sramQ = mem[sramA];

   typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
   typedef struct { bit rd; logic [DW-1:0] d; } ack_t;
   typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; bit acc; bit ovf_before; } dl_vec_t;
   typedef struct { logic [AW-1:0] a; logic [DW-1:0] exp_q; } rd_vec_t;

   wr_t     q_wr[$];
   ack_t    q_ack[$];
   dl_vec_t dv[10];
   rd_vec_t rv[6];

   int   n_chk   = 0;
   int   n_fail  = 0;
   int   n_pulse = 0;
   int   n_ack   = 0;
   int   we_len  = 0;
   logic we_prev = 1'b1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      wr_t  w;
      ack_t k;
      @(negedge clock);
      if (!reset) begin
         we_prev = 1'b1;
         we_len  = 0;
      end else begin
         chk("bus_turnaround", {31'd0, sramDe & ~sramOe}, 32'd0);
         if (!sramWe && we_prev) begin
            n_pulse++;
            if (q_wr.size() == 0) begin
               chk("unexpected_sram_write", 32'd1, 32'd0);
            end else begin
               w = q_wr.pop_front();
               chk("sram_wr_addr", sramA, w.a);
               chk("sram_wr_data", sramD, w.d);
               chk("sram_wr_de", sramDe, 1'b1);
            end
         end
         if (!sramWe) begin
            we_len++;
         end else if (!we_prev) begin
            chk("we_low_cycles", we_len, WS);
            we_len = 0;
         end
         we_prev = sramWe;
         if (cpuAck) begin
            n_ack++;
            if (q_ack.size() == 0) begin
               chk("unexpected_cpuAck", 32'd1, 32'd0);
            end else begin
               k = q_ack.pop_front();
               if (k.rd) chk("cpuQ", cpuQ, k.d);
            end
         end
      end
   endtask

   task automatic wait_idle(input string name);
      int k = 0;
      while (busy && k < 200) begin
         tick();
         k++;
      end
      chk(name, busy, 1'b0);
   endtask

   task automatic drive_dl(input int first, input int last);
      for (int i = first; i <= last; i++) begin
         chk($sformatf("ovf_before_%0d", i), ovf, dv[i].ovf_before);
         iniW = 1'b1;
         iniA = dv[i].a;
         iniD = dv[i].d;
         if (dv[i].acc) q_wr.push_back('{a: dv[i].a, d: dv[i].d});
         tick();
      end
      iniW = 1'b0;
   endtask

   // Issued just after a negedge; lat = edges after the sampling edge until cpuAck.
   task automatic cpu_op(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [DW-1:0] exp_q, output int lat);
      cpuReq = 1'b1;
      cpuWe  = we;
      cpuA   = a;
      cpuD   = d;
      if (we) q_wr.push_back('{a: a, d: d});
      q_ack.push_back('{rd: !we, d: exp_q});
      tick();
      cpuReq = 1'b0;
      lat = 0;
      while (!cpuAck && lat < 200) begin
         tick();
         lat++;
      end
      chk("cpu_ack_seen", cpuAck, 1'b1);
   endtask

   initial begin
      int lat;
      int k;
      int ack0;
      int pulse0;

      for (int i = 0; i < 4; i++)
         dv[i] = '{a: AW'(i), d: DW'(8'hA5 + i), acc: 1'b1, ovf_before: 1'b0};
      for (int i = 0; i < 6; i++)
         dv[4+i] = '{a: AW'(32'h40000 + i), d: DW'(8'h50 + i), acc: (i < 5), ovf_before: 1'b0};
      rv[0] = '{a: 19'h00002, exp_q: 8'hA7};
      rv[1] = '{a: 19'h00000, exp_q: 8'hA5};
      rv[2] = '{a: 19'h00003, exp_q: 8'hA8};
      rv[3] = '{a: 19'h40000, exp_q: 8'h50};
      rv[4] = '{a: 19'h40004, exp_q: 8'h54};
      rv[5] = '{a: 19'h40005, exp_q: 8'h00};

      // Reset values
      #2 reset = 1'b0;
      tick();
      tick();
      chk("rst_sramWe", sramWe, 1'b1);
      chk("rst_sramOe", sramOe, 1'b1);
      chk("rst_sramDe", sramDe, 1'b0);
      chk("rst_sramA", sramA, '0);
      chk("rst_sramD", sramD, '0);
      chk("rst_cpuAck", cpuAck, 1'b0);
      chk("rst_cpuQ", cpuQ, '0);
      chk("rst_ovf", ovf, 1'b0);
      chk("rst_busy", busy, 1'b1);
      reset = 1'b1;
      tick();
      tick();

      // Four back-to-back download bytes
      drive_dl(0, 3);
      chk("busy_during_dl", busy, 1'b1);
      init = 1'b1;
      wait_idle("busy_fall_t1");
      chk("t1_pulses_at_busy_fall", n_pulse, 4);
      chk("t1_de_at_busy_fall", sramDe, 1'b0);
      chk("t1_ovf", ovf, 1'b0);
      for (int i = 0; i < 4; i++) chk($sformatf("t1_mem_%0d", i), mem[dv[i].a], dv[i].d);

      // Six-byte burst: four buffered plus one popped, last dropped
      init = 1'b0;
      drive_dl(4, 9);
      chk("t2_ovf_set", ovf, 1'b1);
      init = 1'b1;
      wait_idle("busy_fall_t2");
      chk("t2_pulses", n_pulse, 9);
      tick();
      chk("t2_ovf_sticky", ovf, 1'b1);

      // CPU reads from an idle arbiter
      for (int i = 0; i < 6; i++) begin
         cpu_op(1'b0, rv[i].a, 8'h00, rv[i].exp_q, lat);
         chk($sformatf("read_latency_%0d", i), lat, RL + 2);
         tick();
      end

      cpu_op(1'b1, 19'h00200, 8'h77, 8'h00, lat);
      chk("write_latency", lat, WS + 4);
      tick();
      cpu_op(1'b0, 19'h00200, 8'h00, 8'h77, lat);
      tick();

      // CPU write arriving mid-download waits for the FIFO to drain
      init   = 1'b0;
      pulse0 = n_pulse;
      ack0   = n_ack;
      for (int i = 0; i < 4; i++) begin
         iniW = 1'b1;
         iniA = AW'(32'h20000 + i);
         iniD = DW'(8'h11 + i);
         q_wr.push_back('{a: iniA, d: iniD});
         if (i == 1) begin
            cpuReq = 1'b1;
            cpuWe  = 1'b1;
            cpuA   = 19'h7FFFF;
            cpuD   = 8'h3C;
         end
         tick();
         cpuReq = 1'b0;
      end
      iniW = 1'b0;
      q_wr.push_back('{a: 19'h7FFFF, d: 8'h3C});
      q_ack.push_back('{rd: 1'b0, d: 8'h00});
      k = 0;
      while (n_ack == ack0 && k < 300) begin
         tick();
         k++;
      end
      chk("t4_ack_count", n_ack - ack0, 1);
      chk("t4_pulses_at_ack", n_pulse - pulse0, 5);
      chk("t4_mem_7ffff", mem[19'h7FFFF], 8'h3C);
      init = 1'b1;
      wait_idle("busy_fall_t4");

      // Second request before ack is ignored
      pulse0 = n_pulse;
      ack0   = n_ack;
      cpuReq = 1'b1;
      cpuWe  = 1'b1;
      cpuA   = 19'h12345;
      cpuD   = 8'h5A;
      q_wr.push_back('{a: 19'h12345, d: 8'h5A});
      q_ack.push_back('{rd: 1'b0, d: 8'h00});
      tick();
      cpuA = 19'h00100;
      cpuD = 8'hFF;
      tick();
      cpuReq = 1'b0;
      for (int i = 0; i < 30; i++) tick();
      chk("t5_one_ack", n_ack - ack0, 1);
      chk("t5_one_access", n_pulse - pulse0, 1);
      chk("t5_mem_12345", mem[19'h12345], 8'h5A);
      chk("t5_mem_00100", mem[19'h00100], 8'h00);
      chk("wr_queue_drained", q_wr.size(), 0);
      chk("ack_queue_drained", q_ack.size(), 0);

      // Reset in the middle of a write pulse
      init = 1'b0;
      ack0 = n_ack;
      for (int i = 0; i < 3; i++) begin
         iniW = 1'b1;
         iniA = AW'(32'h30000 + i);
         iniD = DW'(8'hC0 + i);
         q_wr.push_back('{a: iniA, d: iniD});
         if (i == 1) begin
            cpuReq = 1'b1;
            cpuWe  = 1'b1;
            cpuA   = 19'h00300;
            cpuD   = 8'h99;
         end
         tick();
         cpuReq = 1'b0;
      end
      iniW = 1'b0;
      k = 0;
      while (sramWe && k < 20) begin
         tick();
         k++;
      end
      chk("t6_pulse_started", sramWe, 1'b0);
      @(posedge clock);
      #2 reset = 1'b0;
      #1;
      chk("t6_we_released", sramWe, 1'b1);
      chk("t6_de_released", sramDe, 1'b0);
      chk("t6_oe_released", sramOe, 1'b1);
      chk("t6_no_ack", cpuAck, 1'b0);
      q_wr.delete();
      q_ack.delete();
      tick();
      reset  = 1'b1;
      pulse0 = n_pulse;
      init   = 1'b1;
      for (int i = 0; i < 30; i++) tick();
      chk("t6_no_ack_after", n_ack - ack0, 0);
      chk("t6_no_access_after", n_pulse - pulse0, 0);
      chk("t6_fifo_empty_busy", busy, 1'b0);
      chk("t6_ovf_cleared", ovf, 1'b0);
      chk("t6_mem_00300", mem[19'h00300], 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
